eth_reset_sequencer: RTL



---
 rtl/eth_reset_seq_pkg.sv | 22 ++
 rtl/eth_reset_sync.sv | 23 ++
 rtl/eth_reset_sequencer.sv | 115 +++++++++++
 3 files changed

// File: rtl/eth_reset_seq_pkg.sv
// Shared types and width helpers for the Ethernet reset sequencer.
// Imported by the sequencer top and reusable by neighbouring blocks.
package eth_reset_seq_pkg;

    typedef enum logic [2:0] {
        SYNC,
        HOLD,
        WAIT,
        DONE,
        FAULT
    } seq_state_e;

    // Bits needed to hold values 0..max_count (never narrower than one bit).
    function automatic int count_width(input int max_count);
        return (max_count < 2) ? 1 : $clog2(max_count + 1);
    endfunction

    function automatic int index_width(input int entries);
        return (entries < 2) ? 1 : $clog2(entries);
    endfunction

endpackage

// File: rtl/eth_reset_sync.sv
// Async-assert / sync-deassert reset synchroniser.
// Also instantiated on its own in the other Ethernet clock domains.
module eth_reset_sync #(
    parameter int sync_stages_p = 2
) (
    input  logic clk_i,
    input  logic reset_n_i,
    output logic sync_reset_n_o
);

    logic [sync_stages_p-1:0] chain;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            chain <= '0;
        end else begin
            chain <= {chain[sync_stages_p-2:0], 1'b1};
        end
    end

    assign sync_reset_n_o = chain[sync_stages_p-1];

endmodule

// File: rtl/eth_reset_sequencer.sv
// Ordered release of the Ethernet subsystem resets, with per-stage hold time,
// optional ready/lock gating, timeout fault and software re-sequencing.
module eth_reset_sequencer
    import eth_reset_seq_pkg::*;
#(
    parameter int                      num_stages_p     = 4,
    parameter int                      hold_cycles_p    = 16,
    parameter logic [num_stages_p-1:0] ready_mask_p     = '0,
    parameter int                      timeout_cycles_p = 1024,
    parameter int                      sync_stages_p    = 2
) (
    input  logic                                 clk_i,
    input  logic                                 reset_n_i,
    input  logic                                 soft_reset_i,
    input  logic [num_stages_p-1:0]              ready_i,
    output logic [num_stages_p-1:0]              reset_o,
    output logic [count_width(num_stages_p)-1:0] stage_o,
    output logic                                 done_o,
    output logic                                 fault_o
);

    localparam int StageW = count_width(num_stages_p);
    localparam int IdxW   = index_width(num_stages_p);
    localparam int CntW   = count_width(hold_cycles_p);
    localparam int TcntW  = count_width(timeout_cycles_p);

    localparam logic [CntW-1:0]  HoldLast    = CntW'(hold_cycles_p - 1);
    localparam logic [TcntW-1:0] TimeoutLast =
        TcntW'((timeout_cycles_p > 0) ? timeout_cycles_p - 1 : 0);
    localparam logic [IdxW-1:0]  LastIdx     = IdxW'(num_stages_p - 1);

    logic             sync_reset_n;
    seq_state_e       state;
    logic [IdxW-1:0]  stage_idx;
    logic [CntW-1:0]  hold_cnt;
    logic [TcntW-1:0] wait_cnt;

    eth_reset_sync #(
        .sync_stages_p(sync_stages_p)
    ) u_sync (
        .clk_i         (clk_i),
        .reset_n_i     (reset_n_i),
        .sync_reset_n_o(sync_reset_n)
    );

    // Soft reset parks the FSM at the start of HOLD for stage 0 and wins over
    // any hold expiry, ready or timeout seen in the same cycle.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state     <= SYNC;
            stage_idx <= '0;
            hold_cnt  <= '0;
            wait_cnt  <= '0;
            reset_o   <= '1;
            stage_o   <= '0;
            done_o    <= 1'b0;
            fault_o   <= 1'b0;
        end else if (soft_reset_i && (state != SYNC)) begin
            state     <= HOLD;
            stage_idx <= '0;
            hold_cnt  <= '0;
            wait_cnt  <= '0;
            reset_o   <= '1;
            stage_o   <= '0;
            done_o    <= 1'b0;
            fault_o   <= 1'b0;
        end else begin
            case (state)
                SYNC: begin
                    if (sync_reset_n) begin
                        state     <= HOLD;
                        stage_idx <= '0;
                        hold_cnt  <= '0;
                    end
                end
                HOLD: begin
                    if (hold_cnt == HoldLast) begin
                        reset_o[stage_idx] <= 1'b0;
                        stage_o            <= stage_o + StageW'(1);
                        hold_cnt           <= '0;
                        if (stage_idx == LastIdx) begin
                            state  <= DONE;
                            done_o <= 1'b1;
                        end else if (ready_mask_p[stage_idx]) begin
                            state    <= WAIT;
                            wait_cnt <= '0;
                        end else begin
                            stage_idx <= stage_idx + IdxW'(1);
                        end
                    end else begin
                        hold_cnt <= hold_cnt + CntW'(1);
                    end
                end
                WAIT: begin
                    if (ready_i[stage_idx]) begin
                        state     <= HOLD;
                        stage_idx <= stage_idx + IdxW'(1);
                        hold_cnt  <= '0;
                    end else if ((timeout_cycles_p != 0) && (wait_cnt == TimeoutLast)) begin
                        state   <= FAULT;
                        fault_o <= 1'b1;
                    end else if (timeout_cycles_p != 0) begin
                        wait_cnt <= wait_cnt + TcntW'(1);
                    end
                end
                DONE, FAULT: begin
                end
                default: begin
                    state <= SYNC;
                end
            endcase
        end
    end

endmodule
